// File: rtl/riscv_pkg.sv
// Shared constants for the 5-stage RISC-V core: datapath widths, control-bundle
// field offsets and result-source encodings.
package riscv_pkg;
  localparam int XLEN  = 32;
  localparam int RAW   = 5;
  localparam int CTRLW = 10;

  // {regwrite, resultsrc[1:0], memwrite, jump, branch, alusrc, alucontrol[2:0]}
  localparam int CTRL_REGWRITE     = 9;
  localparam int CTRL_RESULTSRC_HI = 8;
  localparam int CTRL_RESULTSRC_LO = 7;
  localparam int CTRL_MEMWRITE     = 6;
  localparam int CTRL_JUMP         = 5;
  localparam int CTRL_BRANCH       = 4;
  localparam int CTRL_ALUSRC       = 3;
  localparam int CTRL_ALUCTRL_HI   = 2;
  localparam int CTRL_ALUCTRL_LO   = 0;

  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;
endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the destination
// of a load currently sitting in EX. Purely combinational.
module hazard_detect #(
  parameter int RAW = riscv_pkg::RAW
) (
  input  logic           ex_valid,
  input  logic [1:0]     ex_resultsrc,
  input  logic [RAW-1:0] ex_rd,
  input  logic           id_valid,
  input  logic [RAW-1:0] id_rs1,
  input  logic [RAW-1:0] id_rs2,
  output logic           lu
);
  import riscv_pkg::*;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign lu = ex_valid && (ex_resultsrc == RESULTSRC_LOAD) && (ex_rd != '0) &&
              id_valid && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and branch flush.
// Define ID_EX_PERF_EN to build the bubble/flush performance counters.
module id_ex_stage #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int RAW   = riscv_pkg::RAW,
  parameter int CTRLW = riscv_pkg::CTRLW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_pc4,
  input  logic [XLEN-1:0]  id_rd1,
  input  logic [XLEN-1:0]  id_rd2,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [RAW-1:0]   id_rs1,
  input  logic [RAW-1:0]   id_rs2,
  input  logic [RAW-1:0]   id_rd,
  input  logic [CTRLW-1:0] id_ctrl,
  input  logic             flush_e,
  input  logic             hold_e,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_pc4,
  output logic [XLEN-1:0]  ex_rd1,
  output logic [XLEN-1:0]  ex_rd2,
  output logic [XLEN-1:0]  ex_imm,
  output logic [RAW-1:0]   ex_rs1,
  output logic [RAW-1:0]   ex_rs2,
  output logic [RAW-1:0]   ex_rd,
  output logic [CTRLW-1:0] ex_ctrl,
  output logic             stall_f,
  output logic             stall_d,
  output logic [31:0]      bubble_cnt,
  output logic [31:0]      flush_cnt
);
  import riscv_pkg::*;

  logic lu;
  logic kill;

  hazard_detect #(.RAW(RAW)) u_hazard (
    .ex_valid     (ex_valid),
    .ex_resultsrc (ex_ctrl[CTRL_RESULTSRC_HI:CTRL_RESULTSRC_LO]),
    .ex_rd        (ex_rd),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .lu           (lu)
  );

  // Flush and hold both take precedence, so neither lets a stall escape
  assign stall_f = lu & ~flush_e & ~hold_e;
  assign stall_d = stall_f;
  assign kill    = flush_e | (~hold_e & lu);

  always_ff @(posedge clk or posedge reset) begin
    if (reset || kill) begin
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_pc4   <= '0;
      ex_rd1   <= '0;
      ex_rd2   <= '0;
      ex_imm   <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
      ex_ctrl  <= '0;
    end else if (!hold_e) begin
      ex_valid <= id_valid;
      ex_pc    <= id_pc;
      ex_pc4   <= id_pc4;
      ex_rd1   <= id_rd1;
      ex_rd2   <= id_rd2;
      ex_imm   <= id_imm;
      ex_rs1   <= id_rs1;
      ex_rs2   <= id_rs2;
      ex_rd    <= id_rd;
      ex_ctrl  <= id_valid ? id_ctrl : '0;
    end
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] bub_q, fl_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bub_q <= '0;
      fl_q  <= '0;
    end else begin
      if (stall_d && (bub_q != 32'hFFFF_FFFF)) bub_q <= bub_q + 32'd1;
      if (flush_e && (fl_q != 32'hFFFF_FFFF))  fl_q  <= fl_q + 32'd1;
    end
  end

  assign bubble_cnt = bub_q;
  assign flush_cnt  = fl_q;
`else
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic against a
// transaction-level model of the EX slot.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_pc, id_pc4, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [9:0]  id_ctrl;
  logic        flush_e, hold_e;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [9:0]  ex_ctrl;
  logic        stall_f, stall_d;
  logic [31:0] bubble_cnt, flush_cnt;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc), .id_pc4(id_pc4),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_ctrl(id_ctrl), .flush_e(flush_e), .hold_e(hold_e),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .stall_f(stall_f), .stall_d(stall_d), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [9:0] C_LW  = 10'h288;  // regwrite, resultsrc=load, alusrc
  localparam logic [9:0] C_ADD = 10'h200;  // regwrite only

  typedef struct {
    logic        v;
    logic [31:0] pc, pc4, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [9:0]  ctrl;
  } ex_t;

  ex_t         m;
  logic [31:0] m_bub, m_fl;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_clear();
    m.v = 0; m.pc = 0; m.pc4 = 0; m.rd1 = 0; m.rd2 = 0; m.imm = 0;
    m.rs1 = 0; m.rs2 = 0; m.rd = 0; m.ctrl = 0;
  endtask

  // A dependency exists only on a real load into a nonzero register that ID reads
  function automatic logic m_lu();
    return m.v && (m.ctrl[8:7] == 2'b01) && (m.rd != 0) && id_valid &&
           ((m.rd == id_rs1) || (m.rd == id_rs2));
  endfunction

  task automatic check_ex(input string tag);
    chk({tag, ".valid"}, ex_valid, m.v);
    chk({tag, ".pc"},    ex_pc,    m.pc);
    chk({tag, ".pc4"},   ex_pc4,   m.pc4);
    chk({tag, ".rd1"},   ex_rd1,   m.rd1);
    chk({tag, ".rd2"},   ex_rd2,   m.rd2);
    chk({tag, ".imm"},   ex_imm,   m.imm);
    chk({tag, ".rs1"},   ex_rs1,   m.rs1);
    chk({tag, ".rs2"},   ex_rs2,   m.rs2);
    chk({tag, ".rd"},    ex_rd,    m.rd);
    chk({tag, ".ctrl"},  ex_ctrl,  m.ctrl);
`ifdef ID_EX_PERF_EN
    chk({tag, ".bub"},   bubble_cnt, m_bub);
    chk({tag, ".fl"},    flush_cnt,  m_fl);
`else
    chk({tag, ".bub"},   bubble_cnt, 32'd0);
    chk({tag, ".fl"},    flush_cnt,  32'd0);
`endif
  endtask

  // Check the combinational stall, advance the model one edge, check EX outputs
  task automatic cycle(input string tag);
    logic lu;
    #1;
    lu = m_lu();
    chk({tag, ".stall_f"}, stall_f, lu && !flush_e && !hold_e);
    chk({tag, ".stall_d"}, stall_d, lu && !flush_e && !hold_e);
    if (flush_e) begin
      m_clear(); m_fl++;
    end else if (hold_e) begin
      // EX slot unchanged
    end else if (lu) begin
      m_clear(); m_bub++;
    end else begin
      m.v = id_valid; m.pc = id_pc; m.pc4 = id_pc4; m.rd1 = id_rd1; m.rd2 = id_rd2;
      m.imm = id_imm; m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
      m.ctrl = id_valid ? id_ctrl : 10'd0;
    end
    @(posedge clk); #1;
    check_ex(tag);
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [9:0] ctrl);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_ctrl = ctrl;
    id_pc = $urandom; id_pc4 = id_pc + 4; id_rd1 = $urandom; id_rd2 = $urandom;
    id_imm = $urandom;
  endtask

  initial begin
    reset = 1; flush_e = 0; hold_e = 0;
    set_id(0, 0, 0, 0, 0);
    m_clear(); m_bub = 0; m_fl = 0;
    @(posedge clk); #1;
    check_ex("rst");
    chk("rst.stall", stall_d, 1'b0);
    reset = 0;

    // plain pass-through
    set_id(1, 5'd3, 5'd4, 5'd9, 10'h2A5);
    id_pc = 32'h100; id_rd1 = 32'hDEAD_BEEF;
    cycle("pt");
    chk("pt.pc_lit",   ex_pc,    32'h100);
    chk("pt.rd1_lit",  ex_rd1,   32'hDEAD_BEEF);
    chk("pt.ctrl_lit", ex_ctrl,  10'h2A5);
    chk("pt.v_lit",    ex_valid, 1'b1);

    // load-use: lw x5 then add x6,x5,x1
    set_id(1, 5'd2, 5'd0, 5'd5, C_LW);
    cycle("lw5");
    set_id(1, 5'd5, 5'd1, 5'd6, C_ADD);
    #1 chk("lu.stall_lit", stall_d, 1'b1);
    cycle("lu");
    chk("lu.v_lit",    ex_valid, 1'b0);
    chk("lu.ctrl_lit", ex_ctrl,  10'd0);
    cycle("lu2");
    chk("lu2.rd_lit",  ex_rd,    5'd6);
    chk("lu2.v_lit",   ex_valid, 1'b1);

    // load to x0 never stalls
    set_id(1, 5'd1, 5'd2, 5'd0, C_LW);
    cycle("lwx0");
    set_id(1, 5'd0, 5'd0, 5'd7, C_ADD);
    #1 chk("x0.stall_lit", stall_d, 1'b0);
    cycle("x0");
    chk("x0.v_lit", ex_valid, 1'b1);

    // flush together with a hazard
    set_id(1, 5'd1, 5'd2, 5'd7, C_LW);
    cycle("lw7");
    set_id(1, 5'd7, 5'd3, 5'd8, C_ADD);
    flush_e = 1;
    #1 chk("fl.stall_lit", stall_d, 1'b0);
    cycle("fl");
    flush_e = 0;
    chk("fl.v_lit", ex_valid, 1'b0);

    // hold for 3 cycles with a pending hazard and changing ID
    set_id(1, 5'd1, 5'd2, 5'd9, C_LW);
    cycle("lw9");
    hold_e = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 5'd9, 5'($urandom_range(0, 31)), 5'($urandom_range(1, 31)), 10'($urandom));
      #1 chk("hold.stall_lit", stall_d, 1'b0);
      cycle("hold");
      chk("hold.rd_lit", ex_rd, 5'd9);
    end
    hold_e = 0;
    set_id(1, 5'd3, 5'd4, 5'd10, C_ADD);
    cycle("rel");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0) ? C_LW : 10'($urandom));
      flush_e = ($urandom_range(0, 9) == 0);
      hold_e  = ($urandom_range(0, 7) == 0);
      cycle("rnd");
    end
    flush_e = 0; hold_e = 0;

    // asynchronous reset in the middle of a stall
    set_id(1, 5'd1, 5'd2, 5'd11, C_LW);
    cycle("lw11");
    set_id(1, 5'd11, 5'd0, 5'd12, C_ADD);
    #1 chk("ar.pre_stall", stall_d, 1'b1);
    @(negedge clk);
    reset = 1;
    #1;
    m_clear(); m_bub = 0; m_fl = 0;
    chk("ar.stall_f", stall_f, 1'b0);
    chk("ar.stall_d", stall_d, 1'b0);
    check_ex("ar");
    @(negedge clk);
    reset = 0;
    set_id(1, 5'd1, 5'd2, 5'd13, C_ADD);
    cycle("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
